// File: rtl/tt_bist_pkg.sv
// Shared constants, state encoding and LFSR/MISR step functions for the pin BIST.
package tt_bist_pkg;

  localparam int unsigned SIG_W = 16;
  localparam int unsigned CNT_W = 17;

  localparam logic [SIG_W-1:0] STIM_POLY = 16'hB400;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h002D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  // An all-zero seed would lock the LFSR at zero.
  function automatic logic [SIG_W-1:0] sanitize_seed(input logic [SIG_W-1:0] seed);
    return (seed == '0) ? 16'h0001 : seed;
  endfunction

  // One Galois shift of the stimulus LFSR.
  function automatic logic [SIG_W-1:0] stim_step(input logic [SIG_W-1:0] s);
    return {1'b0, s[SIG_W-1:1]} ^ (s[0] ? STIM_POLY : '0);
  endfunction

  // One MISR compression step with a zero-extended response word.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                 input logic [SIG_W-1:0] d);
    return {m[SIG_W-2:0], 1'b0} ^ (m[SIG_W-1] ? MISR_POLY : '0) ^ d;
  endfunction

endpackage

// File: rtl/tt_pin_bist_if.sv
// Control and pin bus between the BIST harness and its surroundings.
// Optional feature macro: TT_PIN_BIST_XMASK_EN adds the xmask response mask.
interface tt_pin_bist_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
);

  logic             ena;
  logic             start;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [15:0]      signature;
  logic             pass;
`ifdef TT_PIN_BIST_XMASK_EN
  logic [OUT_W-1:0] xmask;

  modport slave (
    input  ena, start, dut_out, xmask,
    output dut_in, busy, done, signature, pass
  );

  modport master (
    output ena, start, dut_out, xmask,
    input  dut_in, busy, done, signature, pass
  );
`else
  modport slave (
    input  ena, start, dut_out,
    output dut_in, busy, done, signature, pass
  );

  modport master (
    output ena, start, dut_out,
    input  dut_in, busy, done, signature, pass
  );
`endif

endinterface

// File: rtl/tt_bist_misr.sv
// 16-bit multiple-input signature register with synchronous clear.
module tt_bist_misr
  import tt_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [SIG_W-1:0] data_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Clear wins over absorb.
  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = misr_step(sig_q, data_i);
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/tt_pin_bist.sv
// Pin-level self-test harness: LFSR stimulus out, MISR-compressed response in.
// Optional feature macro: TT_PIN_BIST_XMASK_EN masks response bits before compression.
module tt_pin_bist
  import tt_bist_pkg::*;
#(
  parameter int unsigned IN_W       = 8,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned NUM_VEC    = 256,
  parameter int unsigned LAT        = 0,
  parameter logic [15:0] STIM_SEED  = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input logic           clk,
  input logic           rst_n,
  tt_pin_bist_if.slave  bist_if
);

  localparam logic [SIG_W-1:0] SEED_C = sanitize_seed(STIM_SEED);
  localparam logic [CNT_W-1:0] NV_C   = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_VEC + LAT - 1);
  localparam logic [CNT_W:0]   LAT_C  = (CNT_W + 1)'(LAT);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [SIG_W-1:0] lfsr_q, lfsr_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             launch_c;
  logic             misr_clr_c;
  logic             misr_en_c;
  logic [OUT_W-1:0] resp_c;
  logic [SIG_W-1:0] absorb_c;
  logic [SIG_W-1:0] sig_c;

  // Response word fed to the MISR, optionally with unknown bits forced to 0.
`ifdef TT_PIN_BIST_XMASK_EN
  assign resp_c = bist_if.dut_out & ~bist_if.xmask;
`else
  assign resp_c = bist_if.dut_out;
`endif
  assign absorb_c = SIG_W'(resp_c);

  // A run starts from IDLE or DONE; start is ignored while running.
  assign launch_c = bist_if.start && bist_if.ena && (state_q != RUN);

  // Next-state and output logic. lfsr_q always holds the next vector to apply,
  // so vector 0 is driven straight from the seed on the launch edge.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    lfsr_d     = lfsr_q;
    dut_in_d   = dut_in_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    misr_clr_c = 1'b0;
    misr_en_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        dut_in_d = '0;
      end
      RUN: begin
        if (!bist_if.ena) begin
          state_d    = IDLE;
          cyc_d      = '0;
          dut_in_d   = '0;
          busy_d     = 1'b0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          misr_clr_c = 1'b1;
        end else begin
          cyc_d     = cyc_q + CNT_W'(1);
          misr_en_c = ({1'b0, cyc_q} + (CNT_W + 1)'(1)) > LAT_C;
          if ((cyc_q + CNT_W'(1)) < NV_C) begin
            dut_in_d = lfsr_q[IN_W-1:0];
            lfsr_d   = stim_step(lfsr_q);
          end else begin
            dut_in_d = '0;
          end
          if (cyc_q == LAST_C) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (misr_step(sig_c, absorb_c) == GOLDEN_SIG);
          end
        end
      end
      DONE: begin
        dut_in_d = '0;
        if (!bist_if.ena) begin
          state_d    = IDLE;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          misr_clr_c = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        dut_in_d = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pass_d   = 1'b0;
      end
    endcase

    if (launch_c) begin
      state_d    = RUN;
      cyc_d      = '0;
      dut_in_d   = SEED_C[IN_W-1:0];
      lfsr_d     = stim_step(SEED_C);
      busy_d     = 1'b1;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      misr_clr_c = 1'b1;
    end
  end

  // State, counter, stimulus and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      lfsr_q   <= SEED_C;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      lfsr_q   <= lfsr_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  tt_bist_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (misr_clr_c),
    .en_i   (misr_en_c),
    .data_i (absorb_c),
    .sig_o  (sig_c)
  );

  assign bist_if.dut_in    = dut_in_q;
  assign bist_if.busy      = busy_q;
  assign bist_if.done      = done_q;
  assign bist_if.pass      = pass_q;
  assign bist_if.signature = sig_c;

endmodule

// File: tb/tb_tt_pin_bist.sv
// Self-checking bench for tt_pin_bist: directed loopback runs plus randomized
// response runs checked against a reference model of the LFSR/MISR rules.
module tb_tt_pin_bist;

  localparam int unsigned NV4   = 256;
  localparam int unsigned LAT4  = 2;
  localparam logic [15:0] SEED4 = 16'h0000;
  localparam logic [15:0] GOLD4 = 16'h0000;

  logic clk;
  logic rst_n;
  logic start_s;
  logic ena_s;

  int n_chk;
  int n_err;

  tt_pin_bist_if #(.IN_W(8), .OUT_W(8)) if1 ();
  tt_pin_bist_if #(.IN_W(8), .OUT_W(8)) if2 ();
  tt_pin_bist_if #(.IN_W(8), .OUT_W(8)) if3 ();
  tt_pin_bist_if #(.IN_W(12), .OUT_W(10)) if4 ();
  tt_pin_bist_if #(.IN_W(8), .OUT_W(8)) if5 ();
  tt_pin_bist_if #(.IN_W(8), .OUT_W(8)) if6 ();

  tt_pin_bist #(.IN_W(8), .OUT_W(8), .NUM_VEC(1), .LAT(0),
                .STIM_SEED(16'hACE1), .GOLDEN_SIG(16'h00E1))
    u1 (.clk(clk), .rst_n(rst_n), .bist_if(if1));
  tt_pin_bist #(.IN_W(8), .OUT_W(8), .NUM_VEC(2), .LAT(0),
                .STIM_SEED(16'hACE1), .GOLDEN_SIG(16'h01B2))
    u2 (.clk(clk), .rst_n(rst_n), .bist_if(if2));
  tt_pin_bist #(.IN_W(8), .OUT_W(8), .NUM_VEC(2), .LAT(3),
                .STIM_SEED(16'hACE1), .GOLDEN_SIG(16'h0000))
    u3 (.clk(clk), .rst_n(rst_n), .bist_if(if3));
  tt_pin_bist #(.IN_W(12), .OUT_W(10), .NUM_VEC(NV4), .LAT(LAT4),
                .STIM_SEED(SEED4), .GOLDEN_SIG(GOLD4))
    u4 (.clk(clk), .rst_n(rst_n), .bist_if(if4));
  tt_pin_bist #(.IN_W(8), .OUT_W(8), .NUM_VEC(5), .LAT(0),
                .STIM_SEED(16'hACE1), .GOLDEN_SIG(16'h0000))
    u5 (.clk(clk), .rst_n(rst_n), .bist_if(if5));
  tt_pin_bist #(.IN_W(8), .OUT_W(8), .NUM_VEC(5), .LAT(0),
                .STIM_SEED(16'hACE1), .GOLDEN_SIG(16'h1234))
    u6 (.clk(clk), .rst_n(rst_n), .bist_if(if6));

  // Shared control for the directed instances.
  assign if1.start = start_s;  assign if1.ena = ena_s;
  assign if2.start = start_s;  assign if2.ena = ena_s;
  assign if3.start = start_s;  assign if3.ena = ena_s;
  assign if5.start = start_s;  assign if5.ena = ena_s;
  assign if6.start = start_s;  assign if6.ena = ena_s;

  // Loopback, three-stage delayed loopback, and constant-zero responders.
  logic [7:0] d3 [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d3[0] <= '0; d3[1] <= '0; d3[2] <= '0;
    end else begin
      d3[0] <= if3.dut_in; d3[1] <= d3[0]; d3[2] <= d3[1];
    end
  end
  assign if1.dut_out = if1.dut_in;
  assign if2.dut_out = if2.dut_in;
  assign if3.dut_out = d3[2];
  assign if5.dut_out = 8'h00;
  assign if6.dut_out = 8'h00;
`ifdef TT_PIN_BIST_XMASK_EN
  assign if1.xmask = '0;
  assign if2.xmask = '0;
  assign if3.xmask = '0;
  assign if5.xmask = '0;
  assign if6.xmask = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: stimulus LFSR and MISR stepping rules.
  function automatic logic [15:0] m_stim(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] m_misr(input logic [15:0] m, input logic [15:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h002D : 16'h0000) ^ d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One randomized-response run on u4, optionally aborted at cyc=4.
  task automatic run4(input string tag, input bit abort, input logic [9:0] mask);
    logic [15:0] s;
    logic [15:0] m;
    logic [9:0]  r;
    int          bad_in;
    int          bad_busy;
    int          n_done;
    s        = (SEED4 == 16'h0000) ? 16'h0001 : SEED4;
    m        = 16'h0000;
    bad_in   = 0;
    bad_busy = 0;
`ifdef TT_PIN_BIST_XMASK_EN
    if4.xmask = mask;
`endif
    @(negedge clk);
    if4.ena   = 1'b1;
    if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    for (int j = 1; j <= int'(NV4 + LAT4); j++) begin
      if ((j - 1) < int'(NV4)) begin
        if (if4.dut_in !== s[11:0]) bad_in++;
        s = m_stim(s);
      end else if (if4.dut_in !== 12'h000) begin
        bad_in++;
      end
      if (if4.busy !== 1'b1 || if4.done !== 1'b0) bad_busy++;
      r = 10'($urandom);
      if4.dut_out = r;
      if (j >= int'(LAT4) + 1) m = m_misr(m, 16'(r & ~mask));
      if (abort && j == 5) begin
        if4.ena = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_vectors"}, 32'(bad_in), 32'd0);
    chk({tag, "_busy_window"}, 32'(bad_busy), 32'd0);
    if (abort) begin
      @(posedge clk); #1;
      chk({tag, "_busy"}, 32'(if4.busy), 32'd0);
      chk({tag, "_sig"}, 32'(if4.signature), 32'd0);
      chk({tag, "_dut_in"}, 32'(if4.dut_in), 32'd0);
      n_done = 0;
      repeat (8) begin
        if (if4.done !== 1'b0) n_done++;
        @(posedge clk); #1;
      end
      chk({tag, "_no_done"}, 32'(n_done), 32'd0);
    end else begin
      @(posedge clk); #1;
      chk({tag, "_busy_end"}, 32'(if4.busy), 32'd0);
      chk({tag, "_done"}, 32'(if4.done), 32'd1);
      chk({tag, "_sig"}, 32'(if4.signature), 32'(m));
      chk({tag, "_pass"}, 32'(if4.pass), 32'(m == GOLD4));
      chk({tag, "_dut_in"}, 32'(if4.dut_in), 32'd0);
    end
  endtask

  initial begin
    int bad;
    int b1, b2, b3, b5, b6;
    n_chk       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    start_s     = 1'b0;
    ena_s       = 1'b1;
    if4.start   = 1'b0;
    if4.ena     = 1'b1;
    if4.dut_out = '0;
`ifdef TT_PIN_BIST_XMASK_EN
    if4.xmask   = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: everything quiet for 10 cycles.
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if ({if1.busy, if1.done, if1.pass} != 3'b000 || if1.signature != 16'h0 || if1.dut_in != 8'h0) bad++;
      if ({if4.busy, if4.done, if4.pass} != 3'b000 || if4.signature != 16'h0 || if4.dut_in != 12'h0) bad++;
      if ({if6.busy, if6.done, if6.pass} != 3'b000 || if6.signature != 16'h0 || if6.dut_in != 8'h0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Directed short runs, all launched on the same edge.
    b1 = 0; b2 = 0; b3 = 0; b5 = 0; b6 = 0;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (if1.busy) b1++;
      if (if2.busy) b2++;
      if (if3.busy) b3++;
      if (if5.busy) b5++;
      if (if6.busy) b6++;
      if (c == 0) begin
        chk("nv1_vec0", 32'(if1.dut_in), 32'h00E1);
        chk("nv2_vec0", 32'(if2.dut_in), 32'h00E1);
      end
      if (c == 1) begin
        chk("nv1_tail", 32'(if1.dut_in), 32'd0);
        chk("nv1_done", 32'(if1.done), 32'd1);
        chk("nv2_vec1", 32'(if2.dut_in), 32'h0070);
      end
      if (c == 2) begin
        chk("nv2_tail", 32'(if2.dut_in), 32'd0);
        chk("nv2_done", 32'(if2.done), 32'd1);
      end
      @(posedge clk); #1;
    end
    chk("nv1_busy_len", 32'(b1), 32'd1);
    chk("nv2_busy_len", 32'(b2), 32'd2);
    chk("lat3_busy_len", 32'(b3), 32'd5);
    chk("zero_busy_len", 32'(b5), 32'd5);
    chk("zero_g_busy_len", 32'(b6), 32'd5);
    chk("nv1_sig", 32'(if1.signature), 32'h00E1);
    chk("nv2_sig", 32'(if2.signature), 32'h01B2);
    chk("lat3_sig", 32'(if3.signature), 32'h01B2);
    chk("nv1_pass", 32'(if1.pass), 32'd1);
    chk("nv2_pass", 32'(if2.pass), 32'd1);
    chk("lat3_pass", 32'(if3.pass), 32'd0);
    chk("lat3_done", 32'(if3.done), 32'd1);
    chk("zero_pass", 32'(if5.pass), 32'd1);
    chk("zero_done", 32'(if5.done), 32'd1);
    chk("zero_g_pass", 32'(if6.pass), 32'd0);
    chk("zero_g_done", 32'(if6.done), 32'd1);

    // Dropping ena in DONE returns to IDLE and clears the signature.
    @(negedge clk);
    ena_s = 1'b0;
    @(posedge clk); #1;
    chk("done_exit_done", 32'(if2.done), 32'd0);
    chk("done_exit_sig", 32'(if2.signature), 32'd0);
    chk("done_exit_pass", 32'(if5.pass), 32'd0);

    // Randomized runs: normal, restart from DONE, abort, fresh after abort.
    run4("rand_a", 1'b0, 10'h000);
    run4("rand_b", 1'b0, 10'h000);
    run4("abort", 1'b1, 10'h000);
    run4("rand_c", 1'b0, 10'h000);
`ifdef TT_PIN_BIST_XMASK_EN
    run4("mask", 1'b0, 10'h080);
`endif

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    if4.ena   = 1'b1;
    if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    repeat (6) begin
      if4.dut_out = 10'($urandom);
      @(posedge clk);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_busy", 32'(if4.busy), 32'd0);
    chk("areset_dut_in", 32'(if4.dut_in), 32'd0);
    chk("areset_sig", 32'(if4.signature), 32'd0);
    #5;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tt_pin_bist.md
# tt_pin_bist

Parametrised on-chip self-test harness for a Tiny Tapeout user design's pin interface. It drives pseudo-random stimulus onto the design's dedicated inputs, compresses the design's outputs into a 16-bit multiple-input signature register (MISR), and flags pass/fail against a golden signature. It sits between the top-level `tt_um_*` wrapper pins and the user core. It gives silicon bring-up and the cocotb bench the same check without external vector storage.

## Interface
Parameters:
- `IN_W`, 8: stimulus width driven to the DUT, 1..16.
- `OUT_W`, 8: DUT response width compressed, 1..16.
- `NUM_VEC`, 256: vectors per run, 1..65535.
- `LAT`, 0: DUT pipeline latency in cycles, 0..15.
- `STIM_SEED`, 16'hACE1: stimulus LFSR seed; 0 is replaced by 16'h0001.
- `GOLDEN_SIG`, 16'h0000: expected final signature.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ena` in 1: design selected; low aborts any run.
- `start` in 1: begin a run (level-sampled).
- `dut_in` out IN_W: stimulus to the DUT, registered.
- `dut_out` in OUT_W: DUT response.
- `busy` out 1: run in progress.
- `done` out 1: run complete, signature valid.
- `signature` out 16: MISR contents.
- `pass` out 1: `done && signature == GOLDEN_SIG`.

## Operation
- States: IDLE, RUN, DONE.
- Stimulus LFSR: 16-bit Galois, `next = (s >> 1) ^ (s[0] ? 16'hB400 : 0)`. `dut_in = s[IN_W-1:0]`.
- MISR: `next = {m[14:0],1'b0} ^ (m[15] ? 16'h002D : 0) ^ zero_ext(dut_out)`. Seed 0.
- IDLE: `dut_in`=0, `busy`=`done`=0. `start && ena` at an edge loads the LFSR with the seed, clears MISR and the cycle counter `cyc`, and moves to RUN.
- RUN: `cyc` increments every cycle.
  - While `cyc < NUM_VEC`: apply the current LFSR value, then advance the LFSR.
  - When `cyc >= NUM_VEC`: `dut_in` holds 0.
  - While `LAT <= cyc < NUM_VEC+LAT`: the MISR absorbs `dut_out`.
  - After the absorb at `cyc == NUM_VEC+LAT-1`: move to DONE.
- DONE: `done`=1, `signature` frozen, `pass` valid, `dut_in`=0.
  - `start && ena` restarts the run exactly as from IDLE.
  - `ena` low moves to IDLE and clears the signature.
- `start` is ignored in RUN.
- `ena` low in RUN: IDLE on the next edge, MISR cleared, `dut_in`=0, no `done` pulse.
- Counter width: 17 bits, so no wrap within the legal parameter range.

## Timing
- Reset values: `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0, state IDLE, LFSR=seed.
- `start` sampled high at edge N:
  - `busy`=1 from edge N.
  - Vector k is visible after edge N+k.
  - The response to vector k is absorbed at edge N+k+1+LAT.
  - `done` rises after edge N+NUM_VEC+LAT.
  - `busy` falls at the same edge.
- Run length: `busy` high for exactly NUM_VEC+LAT cycles.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous).

## Configuration
- `TT_PIN_BIST_XMASK_EN` defined:
  - Adds input `xmask` (OUT_W). The MISR absorbs `dut_out & ~xmask`.
  - Masked bits are treated as 0; used for bits that are unknown in gate-level or after reset.
- Undefined: no `xmask` port; all bits are absorbed.

## Structure
- Package `tt_bist_pkg` holds:
  - `STIM_POLY` = 16'hB400 and `MISR_POLY` = 16'h002D.
  - The state enum `bist_state_e` {IDLE, RUN, DONE}.
  - The seed-sanitising function.
- Sub-module `tt_bist_misr` (clear, enable, data in, 16-bit signature out) holds the MISR. The FSM, counter and stimulus LFSR stay in the top module.

## Test plan
- Reset/idle check: hold reset, then release with `start`=0. Required: all outputs 0, `dut_in`=0 for 10 cycles.
- Short runs in loopback (`dut_out`=`dut_in`, IN_W=OUT_W=8, LAT=0, seed 16'hACE1):
  - NUM_VEC=1: `dut_in`=8'hE1 for one cycle, `signature`=16'h00E1.
  - NUM_VEC=2: vectors 8'hE1, 8'h70, `signature`=16'h01B2, `done`=1 after 2 busy cycles.
- Latency: same loopback through a 3-stage delay, LAT=3, NUM_VEC=2. Required: `signature`=16'h01B2, `busy` high 5 cycles.
- Abort: drop `ena` at `cyc`=4 of a 256-vector run. Required: IDLE next edge, `busy`=0, `done` never asserts, `signature`=0. A fresh `start` then completes normally.
- Pass flag: constant `dut_out`=0 with GOLDEN_SIG=0 gives `pass`=1. With GOLDEN_SIG=16'h1234 it gives `pass`=0, and `done`=1 in both cases.
- Mask (with `TT_PIN_BIST_XMASK_EN`): `dut_out` bit 7 random, `xmask`=8'h80. Required: the signature matches a run with bit 7 forced to 0.
